// File: rtl/stream_xbar_return.sv
// Return-path router for the forward stream crossbar.
// Each target keeps an in-order FIFO of initiator indices recorded on forward
// handshakes; responses follow the FIFO head back to their initiator, where a
// round-robin arbiter with lock-in merges competing targets.

// Protocol checks for the return router.
module stream_xbar_return_chk #(
  parameter int unsigned NumInp    = 2,
  parameter int unsigned NumOut    = 2,
  parameter int unsigned DataWidth = 1,
  parameter int unsigned IdxWidth  = 1
) (
  input logic                          clk,
  input logic                          rst,
  input logic [NumOut-1:0]             req_push,
  input logic [NumOut*IdxWidth-1:0]    req_idx,
  input logic [NumOut-1:0]             req_full,
  input logic [NumOut-1:0]             rsp_valid,
  input logic [NumOut-1:0]             rsp_ready,
  input logic [NumOut*DataWidth-1:0]   rsp_data,
  input logic [NumOut-1:0]             empty
);

  for (genvar j = 0; j < NumOut; j++) begin : g_chk
    // An index field wider than needed can encode non-existent initiators.
    if ((32'd1 << IdxWidth) > NumInp) begin : g_idx
      a_idx_range: assert property (@(posedge clk) disable iff (rst)
        req_push[j] |-> (32'(req_idx[j*IdxWidth +: IdxWidth]) < NumInp))
        else $error("target %0d: pushed initiator index out of range", j);
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(req_push[j] && req_full[j] && !(rsp_valid[j] && rsp_ready[j])))
      else $error("target %0d: push into full ID FIFO dropped", j);

    a_stable: assert property (@(posedge clk) disable iff (rst)
      (rsp_valid[j] && !rsp_ready[j]) |=>
        (rsp_valid[j] && $stable(rsp_data[j*DataWidth +: DataWidth])))
      else $error("target %0d: response changed while stalled", j);

    a_unmatched: assert property (@(posedge clk) disable iff (rst)
      !(rsp_valid[j] && empty[j]))
      else $warning("target %0d: response with no outstanding ID", j);
  end

endmodule

module stream_xbar_return #(
  parameter int unsigned NumInp    = 2,
  parameter int unsigned NumOut    = 2,
  parameter int unsigned DataWidth = 1,
  parameter int unsigned MaxTxns   = 4,
  parameter int unsigned IdxWidth  = (NumInp > 1) ? $clog2(NumInp) : 1,
  parameter int unsigned SelWidth  = (NumOut > 1) ? $clog2(NumOut) : 1,
  parameter int unsigned CntWidth  = $clog2(MaxTxns + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumOut-1:0]             req_push_i,
  input  logic [NumOut*IdxWidth-1:0]    req_idx_i,
  output logic [NumOut-1:0]             req_full_o,
  output logic [NumOut*CntWidth-1:0]    outstanding_o,
  input  logic [NumOut*DataWidth-1:0]   rsp_data_i,
  input  logic [NumOut-1:0]             rsp_valid_i,
  output logic [NumOut-1:0]             rsp_ready_o,
  output logic [NumInp*DataWidth-1:0]   rsp_data_o,
  output logic [NumInp*SelWidth-1:0]    rsp_sel_o,
  output logic [NumInp-1:0]             rsp_valid_o,
  input  logic [NumInp-1:0]             rsp_ready_i
);

  localparam int unsigned PtrWidth = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;

  logic [IdxWidth-1:0] mem_r  [NumOut][MaxTxns];
  logic [PtrWidth-1:0] wptr_r [NumOut];
  logic [PtrWidth-1:0] rptr_r [NumOut];
  logic [CntWidth-1:0] cnt_r  [NumOut];

  logic [NumOut-1:0]   full_s;
  logic [NumOut-1:0]   empty_s;
  logic [NumOut-1:0]   req_s;
  logic [NumOut-1:0]   push_s;
  logic [NumOut-1:0]   pop_s;
  logic [IdxWidth-1:0] head_s [NumOut];

  logic [NumOut-1:0]   req_vec_s  [NumInp];
  logic [NumInp-1:0]   gnt_valid_s;
  logic [SelWidth-1:0] gnt_sel_s  [NumInp];
  logic [SelWidth-1:0] rr_r       [NumInp];
  logic [SelWidth-1:0] lock_sel_r [NumInp];
  logic [NumInp-1:0]   lock_r;

  // Circular pointer advance with wrap at the last FIFO slot.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxTxns - 1)) ? {PtrWidth{1'b0}} : p + PtrWidth'(1);
  endfunction

  // FIFO status, head index and per-target routing request.
  always_comb begin
    for (int j = 0; j < NumOut; j++) begin
      full_s[j]  = (cnt_r[j] == CntWidth'(MaxTxns));
      empty_s[j] = (cnt_r[j] == {CntWidth{1'b0}});
      head_s[j]  = mem_r[j][rptr_r[j]];
      req_s[j]   = rsp_valid_i[j] && !empty_s[j];
      req_full_o[j] = full_s[j];
      outstanding_o[j*CntWidth +: CntWidth] = cnt_r[j];
    end
  end

  // Push is accepted when there is room or a pop frees a slot this cycle.
  always_comb begin
    for (int j = 0; j < NumOut; j++) begin
      pop_s[j]  = rsp_valid_i[j] && rsp_ready_o[j];
      push_s[j] = req_push_i[j] && (!full_s[j] || pop_s[j]);
    end
  end

  // Decode which targets are asking for each initiator.
  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      for (int j = 0; j < NumOut; j++) begin
        req_vec_s[i][j] = req_s[j] && (head_s[j] == IdxWidth'(i));
      end
    end
  end

  // Round-robin search from rr, overridden by a held grant while stalled.
  always_comb begin
    logic [SelWidth-1:0] rr_sel;
    int unsigned         cand;
    rr_sel = {SelWidth{1'b0}};
    cand   = 32'd0;
    for (int i = 0; i < NumInp; i++) begin
      gnt_valid_s[i] = |req_vec_s[i];
      rr_sel = {SelWidth{1'b0}};
      // Descending scan so the nearest requester at or after rr wins last.
      for (int k = int'(NumOut) - 1; k >= 0; k--) begin
        cand   = (32'(rr_r[i]) + 32'(k)) % NumOut;
        rr_sel = req_vec_s[i][SelWidth'(cand)] ? SelWidth'(cand) : rr_sel;
      end
      gnt_sel_s[i] = (lock_r[i] && req_vec_s[i][lock_sel_r[i]]) ? lock_sel_r[i] : rr_sel;
    end
  end

  // Combinational response outputs and back-pressure to the targets.
  always_comb begin
    rsp_data_o  = {(NumInp*DataWidth){1'b0}};
    rsp_sel_o   = {(NumInp*SelWidth){1'b0}};
    rsp_valid_o = {NumInp{1'b0}};
    rsp_ready_o = {NumOut{1'b0}};
    for (int i = 0; i < NumInp; i++) begin
      rsp_valid_o[i] = gnt_valid_s[i];
      rsp_sel_o[i*SelWidth +: SelWidth] = gnt_valid_s[i] ? gnt_sel_s[i] : {SelWidth{1'b0}};
      rsp_data_o[i*DataWidth +: DataWidth] = gnt_valid_s[i] ?
        rsp_data_i[32'(gnt_sel_s[i])*DataWidth +: DataWidth] : {DataWidth{1'b0}};
    end
    for (int j = 0; j < NumOut; j++) begin
      for (int i = 0; i < NumInp; i++) begin
        rsp_ready_o[j] = rsp_ready_o[j] |
          (req_vec_s[i][j] && gnt_valid_s[i] &&
           (gnt_sel_s[i] == SelWidth'(j)) && rsp_ready_i[i]);
      end
    end
  end

  // ID FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < NumOut; j++) begin
        wptr_r[j] <= {PtrWidth{1'b0}};
        rptr_r[j] <= {PtrWidth{1'b0}};
        cnt_r[j]  <= {CntWidth{1'b0}};
        for (int t = 0; t < MaxTxns; t++) begin
          mem_r[j][t] <= {IdxWidth{1'b0}};
        end
      end
    end else begin
      for (int j = 0; j < NumOut; j++) begin
        if (push_s[j]) begin
          mem_r[j][wptr_r[j]] <= req_idx_i[j*IdxWidth +: IdxWidth];
          wptr_r[j] <= ptr_inc(wptr_r[j]);
        end
        if (pop_s[j]) begin
          rptr_r[j] <= ptr_inc(rptr_r[j]);
        end
        case ({push_s[j], pop_s[j]})
          2'b10:   cnt_r[j] <= cnt_r[j] + CntWidth'(1);
          2'b01:   cnt_r[j] <= cnt_r[j] - CntWidth'(1);
          default: cnt_r[j] <= cnt_r[j];
        endcase
      end
    end
  end

  // Arbiter state: rr advances past the winner, lock holds a stalled grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumInp; i++) begin
        rr_r[i]       <= {SelWidth{1'b0}};
        lock_sel_r[i] <= {SelWidth{1'b0}};
        lock_r[i]     <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NumInp; i++) begin
        if (rsp_valid_o[i] && rsp_ready_i[i]) begin
          rr_r[i]   <= SelWidth'((32'(gnt_sel_s[i]) + 32'd1) % NumOut);
          lock_r[i] <= 1'b0;
        end else if (rsp_valid_o[i]) begin
          lock_r[i]     <= 1'b1;
          lock_sel_r[i] <= gnt_sel_s[i];
        end else begin
          lock_r[i] <= 1'b0;
        end
      end
    end
  end

  stream_xbar_return_chk #(
    .NumInp    (NumInp),
    .NumOut    (NumOut),
    .DataWidth (DataWidth),
    .IdxWidth  (IdxWidth)
  ) u_chk (
    .clk       (clk_i),
    .rst       (rst_i),
    .req_push  (req_push_i),
    .req_idx   (req_idx_i),
    .req_full  (full_s),
    .rsp_valid (rsp_valid_i),
    .rsp_ready (rsp_ready_o),
    .rsp_data  (rsp_data_i),
    .empty     (empty_s)
  );

endmodule

// File: tb/tb_stream_xbar_return.sv
// Scoreboard bench for stream_xbar_return with 2 initiators, 2 targets,
// 8-bit payload and 4 outstanding IDs per target.
module tb_stream_xbar_return;

  localparam int NI = 2;
  localparam int NO = 2;
  localparam int DW = 8;
  localparam int MT = 4;
  localparam int IW = 1;
  localparam int SW = 1;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NO-1:0]     req_push_i;
  logic [NO*IW-1:0]  req_idx_i;
  logic [NO-1:0]     req_full_o;
  logic [NO*CW-1:0]  outstanding_o;
  logic [NO*DW-1:0]  rsp_data_i;
  logic [NO-1:0]     rsp_valid_i;
  logic [NO-1:0]     rsp_ready_o;
  logic [NI*DW-1:0]  rsp_data_o;
  logic [NI*SW-1:0]  rsp_sel_o;
  logic [NI-1:0]     rsp_valid_o;
  logic [NI-1:0]     rsp_ready_i;

  int checks = 0;
  int errors = 0;

  logic [SW+DW-1:0] exp_q [NI][$];
  int               mfifo [NO][$];
  logic [SW+DW-1:0] mon_e;

  always #5 clk = ~clk;

  stream_xbar_return #(
    .NumInp(NI), .NumOut(NO), .DataWidth(DW), .MaxTxns(MT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_push_i    (req_push_i),
    .req_idx_i     (req_idx_i),
    .req_full_o    (req_full_o),
    .outstanding_o (outstanding_o),
    .rsp_data_i    (rsp_data_i),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_ready_o   (rsp_ready_o),
    .rsp_data_o    (rsp_data_o),
    .rsp_sel_o     (rsp_sel_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("leftover_i%0d", i), 32'(exp_q[i].size()), 32'd0);
      exp_q[i].delete();
    end
    for (int j = 0; j < NO; j++) mfifo[j].delete();
  endtask

  task automatic do_reset();
    req_push_i  = '0;
    rsp_valid_i = '0;
    rsp_data_i  = '0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    clear_model();
    tick();
  endtask

  task automatic push(input int j, input int idx);
    req_push_i[j] = 1'b1;
    req_idx_i[j*IW +: IW] = IW'(idx);
    mfifo[j].push_back(idx);
    tick();
    req_push_i[j] = 1'b0;
  endtask

  task automatic push2(input int idx0, input int idx1);
    req_push_i = 2'b11;
    req_idx_i  = {IW'(idx1), IW'(idx0)};
    mfifo[0].push_back(idx0);
    mfifo[1].push_back(idx1);
    tick();
    req_push_i = 2'b00;
  endtask

  // Model: the response from target j belongs to the oldest ID of target j.
  task automatic expect_rsp(input int j, input logic [7:0] d);
    int idx;
    if (mfifo[j].size() == 0) begin
      check("model_empty", 32'd1, 32'd0);
    end else begin
      idx = mfifo[j].pop_front();
      exp_q[idx].push_back({SW'(j), d});
    end
  endtask

  task automatic send_rsp(input int j, input logic [7:0] d);
    bit done;
    done = 1'b0;
    rsp_valid_i[j] = 1'b1;
    rsp_data_i[j*DW +: DW] = d;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = rsp_ready_o[j];
    end
    if (!done) check($sformatf("rsp_timeout_t%0d", j), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rsp_valid_i[j] = 1'b0;
    rsp_data_i[j*DW +: DW] = '0;
  endtask

  // Scoreboard: every initiator-side handshake must match the next expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        if (rsp_valid_o[i] && rsp_ready_i[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_rsp_i%0d", i), 32'd1, 32'd0);
          end else begin
            mon_e = exp_q[i].pop_front();
            check($sformatf("mon_data_i%0d", i), 32'(rsp_data_o[i*DW +: DW]), 32'(mon_e[DW-1:0]));
            check($sformatf("mon_sel_i%0d", i), 32'(rsp_sel_o[i*SW +: SW]), 32'(mon_e[DW +: SW]));
            check($sformatf("mon_tready_i%0d", i), 32'(rsp_ready_o[mon_e[DW +: SW]]), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with targets signalling to show outputs are forced low.
    rst = 1'b1;
    req_push_i = '0; req_idx_i = '0;
    rsp_valid_i = 2'b11; rsp_data_i = 16'hFFFF; rsp_ready_i = 2'b11;
    #7;
    check("rst_valid_o", 32'(rsp_valid_o), 32'd0);
    check("rst_ready_o", 32'(rsp_ready_o), 32'd0);
    check("rst_data_o", 32'(rsp_data_o), 32'd0);
    check("rst_sel_o", 32'(rsp_sel_o), 32'd0);
    check("rst_outstanding", 32'(outstanding_o), 32'd0);
    check("rst_full", 32'(req_full_o), 32'd0);
    rsp_valid_i = '0; rsp_data_i = '0;
    rst = 1'b0;
    tick();

    // Single round trip.
    do_reset();
    rsp_ready_i = 2'b11;
    push(0, 1);
    check("rt_cnt1", 32'(outstanding_o[0 +: CW]), 32'd1);
    expect_rsp(0, 8'hA5);
    rsp_valid_i[0] = 1'b1;
    rsp_data_i[0 +: DW] = 8'hA5;
    @(negedge clk);
    check("rt_valid1", 32'(rsp_valid_o[1]), 32'd1);
    check("rt_valid0", 32'(rsp_valid_o[0]), 32'd0);
    check("rt_data", 32'(rsp_data_o[DW +: DW]), 32'hA5);
    check("rt_sel", 32'(rsp_sel_o[1]), 32'd0);
    check("rt_ready", 32'(rsp_ready_o[0]), 32'd1);
    @(posedge clk); #1;
    rsp_valid_i[0] = 1'b0;
    rsp_data_i[0 +: DW] = '0;
    check("rt_cnt0", 32'(outstanding_o[0 +: CW]), 32'd0);

    // In-order return on target 1.
    do_reset();
    rsp_ready_i = 2'b11;
    push(1, 0); push(1, 1); push(1, 0);
    check("io_cnt3", 32'(outstanding_o[CW +: CW]), 32'd3);
    expect_rsp(1, 8'd1); send_rsp(1, 8'd1);
    expect_rsp(1, 8'd2); send_rsp(1, 8'd2);
    expect_rsp(1, 8'd3); send_rsp(1, 8'd3);
    check("io_cnt0", 32'(outstanding_o[CW +: CW]), 32'd0);

    // Arbitration alternates starting from target 0.
    do_reset();
    rsp_ready_i = 2'b11;
    push2(0, 0); push2(0, 0);
    expect_rsp(0, 8'h10); expect_rsp(1, 8'h20);
    expect_rsp(0, 8'h11); expect_rsp(1, 8'h21);
    fork
      begin send_rsp(0, 8'h10); send_rsp(0, 8'h11); end
      begin send_rsp(1, 8'h20); send_rsp(1, 8'h21); end
    join

    // Ready low: grant stays on target 0 with stable data.
    do_reset();
    rsp_ready_i = 2'b00;
    push2(0, 0);
    expect_rsp(0, 8'h30); expect_rsp(1, 8'h40);
    fork
      send_rsp(0, 8'h30);
      send_rsp(1, 8'h40);
      begin
        for (int n = 0; n < 3; n++) begin
          @(negedge clk);
          check("hold_valid", 32'(rsp_valid_o[0]), 32'd1);
          check("hold_sel", 32'(rsp_sel_o[0]), 32'd0);
          check("hold_data", 32'(rsp_data_o[0 +: DW]), 32'h30);
        end
        @(posedge clk); #1;
        rsp_ready_i[0] = 1'b1;
      end
    join

    // Lock-in: target 0 arriving later does not preempt a stalled target 1.
    do_reset();
    rsp_ready_i = 2'b00;
    push2(0, 0);
    expect_rsp(1, 8'h50); expect_rsp(0, 8'h60);
    fork
      send_rsp(1, 8'h50);
      begin tick(); send_rsp(0, 8'h60); end
      begin
        for (int n = 0; n < 3; n++) begin
          @(negedge clk);
          check("lock_sel", 32'(rsp_sel_o[0]), 32'd1);
          check("lock_data", 32'(rsp_data_o[0 +: DW]), 32'h50);
        end
        @(posedge clk); #1;
        rsp_ready_i[0] = 1'b1;
      end
    join

    // Full, same-cycle push+pop at full, drain and pointer wrap.
    do_reset();
    rsp_ready_i = 2'b11;
    push(0, 1); push(0, 0); push(0, 1);
    check("full_at3", 32'(req_full_o[0]), 32'd0);
    push(0, 1);
    check("full_at4", 32'(req_full_o[0]), 32'd1);
    check("cnt_at4", 32'(outstanding_o[0 +: CW]), 32'd4);
    expect_rsp(0, 8'h77);
    req_push_i[0] = 1'b1;
    req_idx_i[0 +: IW] = 1'b0;
    mfifo[0].push_back(0);
    rsp_valid_i[0] = 1'b1;
    rsp_data_i[0 +: DW] = 8'h77;
    @(negedge clk);
    check("pp_ready", 32'(rsp_ready_o[0]), 32'd1);
    @(posedge clk); #1;
    req_push_i[0] = 1'b0;
    rsp_valid_i[0] = 1'b0;
    rsp_data_i[0 +: DW] = '0;
    check("pp_cnt", 32'(outstanding_o[0 +: CW]), 32'd4);
    check("pp_full", 32'(req_full_o[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      expect_rsp(0, 8'(8'h80 + k));
      send_rsp(0, 8'(8'h80 + k));
    end
    check("drain_cnt", 32'(outstanding_o[0 +: CW]), 32'd0);
    for (int k = 0; k < 10; k++) begin
      push(0, int'($urandom_range(0, 1)));
      expect_rsp(0, 8'(k));
      send_rsp(0, 8'(k));
    end
    check("wrap_cnt", 32'(outstanding_o[0 +: CW]), 32'd0);

    // Unmatched response stalls until an ID arrives, one cycle after push.
    do_reset();
    rsp_ready_i = 2'b11;
    rsp_valid_i[0] = 1'b1;
    rsp_data_i[0 +: DW] = 8'h5A;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("um_ready", 32'(rsp_ready_o[0]), 32'd0);
      check("um_valid_o", 32'(rsp_valid_o), 32'd0);
    end
    @(posedge clk); #1;
    req_push_i[0] = 1'b1;
    req_idx_i[0 +: IW] = 1'b1;
    mfifo[0].push_back(1);
    @(negedge clk);
    check("um_push_cycle", 32'(rsp_ready_o[0]), 32'd0);
    @(posedge clk); #1;
    req_push_i[0] = 1'b0;
    expect_rsp(0, 8'h5A);
    @(negedge clk);
    check("um_release_ready", 32'(rsp_ready_o[0]), 32'd1);
    check("um_release_valid", 32'(rsp_valid_o[1]), 32'd1);
    @(posedge clk); #1;
    rsp_valid_i[0] = 1'b0;
    rsp_data_i[0 +: DW] = '0;

    // Asynchronous reset between edges with 3 outstanding and rr[1] moved.
    do_reset();
    rsp_ready_i = 2'b11;
    push(0, 1); push(0, 1); push(0, 1); push(0, 1);
    expect_rsp(0, 8'h44);
    send_rsp(0, 8'h44);
    check("ar_cnt3", 32'(outstanding_o[0 +: CW]), 32'd3);
    expect_rsp(0, 8'h55);
    rsp_valid_i[0] = 1'b1;
    rsp_data_i[0 +: DW] = 8'h55;
    @(negedge clk);
    check("ar_pre_valid", 32'(rsp_valid_o[1]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid_o", 32'(rsp_valid_o), 32'd0);
    check("ar_ready_o", 32'(rsp_ready_o), 32'd0);
    check("ar_data_o", 32'(rsp_data_o), 32'd0);
    check("ar_sel_o", 32'(rsp_sel_o), 32'd0);
    check("ar_outstanding", 32'(outstanding_o), 32'd0);
    check("ar_full", 32'(req_full_o), 32'd0);
    rsp_valid_i = '0;
    rsp_data_i = '0;
    #1;
    rst = 1'b0;
    clear_model();
    tick();
    check("ar_post_cnt", 32'(outstanding_o), 32'd0);
    // rr[1] back at 0: target 0 must win initiator 1 first.
    push2(1, 1);
    expect_rsp(0, 8'h61); expect_rsp(1, 8'h62);
    fork
      send_rsp(0, 8'h61);
      send_rsp(1, 8'h62);
    join

    tick();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("final_q_i%0d", i), 32'(exp_q[i].size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
